day_set_ctrl: RTL and testbench
===============================

# day_set_ctrl

Day-of-week source for the clock display. Holds the current day as a 3-bit code (0=Mon … 6=Sun) and drives it to the second-letter segment decoder and the other day-letter decoders. It advances on the midnight tick in run mode. In set mode it is stepped up or down by debounced pushbuttons, with a blinking blank output.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples a button level must hold before it is accepted (≥2).
- BLINK_HALF, 8: cycles per blink half-period in set mode (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- set_mode  input  1  level, synchronous to clk; 1 = set mode, 0 = run mode.
- day_tick  input  1  one-cycle pulse, synchronous; midnight rollover from timekeeping.
- btn_up  input  1  raw pushbutton, asynchronous, active-high.
- btn_down  input  1  raw pushbutton, asynchronous, active-high.
- seg  output  3  current day code, 0..6; 7 never driven.
- blank  output  1  1 = display decoders blanked (blink phase).
- set_active  output  1  registered FSM state; 1 while in SET.

## Operation
- Reset (async, rst_n=0): seg=0 (Mon), blank=0, set_active=0, FSM=RUN, synchronizers=0, debounced levels=0, debounce counters=0, blink counter=0.
- Button path, per button: 2-flop synchronizer (s1, s2), then a debounce counter. The counter clears whenever s2 equals the accepted level. The accepted level flips once s2 has differed from it for DEBOUNCE_CYCLES consecutive samples. A 0→1 flip of the accepted level produces a registered one-cycle press pulse. A 1→0 flip produces nothing.
- FSM states:
  - RUN: day_tick advances seg. Press pulses are ignored, but debounce still tracks the buttons.
  - SET: an up press advances seg and a down press retreats it. day_tick is ignored (not queued).
- Transitions: RUN→SET on a clock edge with set_mode=1; SET→RUN on a clock edge with set_mode=0.
- Arithmetic: advance is 6→0, else +1. Retreat is 0→6, else −1. seg never leaves 0..6.
- Simultaneous up and down press pulses in the same cycle in SET: no change.
- Blink: in RUN, blank=0 and the blink counter is held at 0. In SET the counter runs 0..2*BLINK_HALF−1 and wraps. blank=1 for counts BLINK_HALF..2*BLINK_HALF−1. The first half after entering SET is therefore visible (blank=0).
- A button held across a RUN→SET transition does not generate a press in SET, because its accepted level is already 1.

## Timing
- set_mode→set_active: 1 cycle (registered at the first edge sampling the new level).
- day_tick→seg: seg updates at the edge that samples day_tick=1 (RUN only).
- Button latency: call edge 0 the first edge at which btn samples high into s1. s2 is high from edge 1. The accepted level flips at edge DEBOUNCE_CYCLES, the press pulse is high after that edge, and seg changes at edge DEBOUNCE_CYCLES+1.
- Any raw pulse whose s2 run is shorter than DEBOUNCE_CYCLES samples causes no press.
- One press per accepted rising level. Holding a button causes no auto-repeat.
- blank toggles every BLINK_HALF cycles in SET. It goes to 0 at the edge where set_active goes to 0.
- Reset mid-operation: all state returns to reset values immediately, without waiting for clk. A button still held after reset release must go through the full debounce before it is accepted, and it then produces a press.

## Test plan
- Reset then 8 day_tick pulses in RUN → seg sequence 1,2,3,4,5,6,0,1; blank=0 throughout.
- DEBOUNCE_CYCLES=4: set_mode=1, btn_up held 10 cycles → seg 0→1 exactly once, at edge 5 after first sample; a 3-cycle btn_up glitch → no change.
- SET with seg=0, one btn_down press → seg=6. Then one btn_up press → seg=0.
- SET, btn_up and btn_down rising together → no change. day_tick in SET → no change. Return to RUN, then day_tick → +1.
- BLINK_HALF=8, enter SET → blank 0 for 8 cycles, then 1 for 8, repeating. Drop set_mode → blank=0 and set_active=0 one edge later.
- rst_n asserted mid-debounce with seg=4 → seg=0 and blank=0 immediately. The held button, after release of rst_n, is accepted only after the full debounce.

Source files
------------

// File: rtl/day_set_ctrl.sv
// Day-of-week register for the clock display: advances on midnight in run mode,
// stepped by debounced up/down buttons in set mode with a blinking blank.
module day_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_HALF      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_mode,
    input  logic       day_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] seg,
    output logic       blank,
    output logic       set_active
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(2 * BLINK_HALF);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 2);
    localparam logic [BW-1:0] BL_HALF = BW'(BLINK_HALF);
    localparam logic [BW-1:0] BL_MAX  = BW'(2 * BLINK_HALF - 1);

    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [1:0]    raw;
    logic [1:0]    s1_q, s2_q;
    logic [1:0]    lvl_q, lvl_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];
    logic [2:0]    seg_q, seg_d, seg_adv, seg_ret;
    logic [BW-1:0] blink_q, blink_d;

    // Bit 0 is the up button, bit 1 the down button.
    assign raw = {btn_down, btn_up};

    // cnt counts s2 samples differing from the accepted level; s1 is the sample
    // about to enter s2, so the level flips on the edge that completes the run.
    always_comb begin
        lvl_d   = lvl_q;
        press_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = cnt_q[b];
            if (s2_q[b] == lvl_q[b]) begin
                cnt_d[b] = '0;
            end else if ((s1_q[b] != lvl_q[b]) && (cnt_q[b] == DB_LAST)) begin
                lvl_d[b]   = ~lvl_q[b];
                press_d[b] = ~lvl_q[b];
                cnt_d[b]   = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + DW'(1);
            end
        end
    end

    assign seg_adv = (seg_q == 3'd6) ? 3'd0 : seg_q + 3'd1;
    assign seg_ret = (seg_q == 3'd0) ? 3'd6 : seg_q - 3'd1;

    always_comb begin
        state_d = set_mode ? SET : RUN;
        seg_d   = seg_q;
        blink_d = '0;
        if (state_q == RUN) begin
            if (day_tick) begin
                seg_d = seg_adv;
            end
        end else begin
            if (press_q == 2'b01) begin
                seg_d = seg_adv;
            end else if (press_q == 2'b10) begin
                seg_d = seg_ret;
            end
        end
        // Blink phase starts from zero on every entry into SET.
        if ((state_q == SET) && (state_d == SET)) begin
            blink_d = (blink_q == BL_MAX) ? '0 : blink_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            s1_q    <= 2'b00;
            s2_q    <= 2'b00;
            lvl_q   <= 2'b00;
            press_q <= 2'b00;
            seg_q   <= 3'd0;
            blink_q <= '0;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            s1_q    <= raw;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            seg_q   <= seg_d;
            blink_q <= blink_d;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign seg        = seg_q;
    assign set_active = (state_q == SET);
    assign blank      = (state_q == SET) && (blink_q >= BL_HALF);

endmodule

// File: tb/tb_day_set_ctrl.sv
// Bench for day_set_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_day_set_ctrl;
    localparam int D = 4;
    localparam int H = 8;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       set_mode = 1'b0;
    logic       day_tick = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] seg;
    logic       blank;
    logic       set_active;

    int n_checks = 0;
    int n_pass   = 0;

    day_set_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .BLINK_HALF     (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_mode  (set_mode),
        .day_tick  (day_tick),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .seg       (seg),
        .blank     (blank),
        .set_active(set_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    // Model: a button is accepted once the last D raw samples (each reaching the
    // debouncer one edge after it is taken) all disagree with the accepted level.
    int m_seg     = 0;
    int m_setcyc  = 0;
    bit m_set     = 1'b0;
    bit m_lvl   [2];
    bit m_press [2];
    bit m_win   [2][D];
    bit m_raw   [2];
    bit all_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_seg    = 0;
            m_setcyc = 0;
            m_set    = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b]   = 1'b0;
                m_press[b] = 1'b0;
                for (int j = 0; j < D; j++) m_win[b][j] = 1'b0;
            end
        end else begin
            if (!m_set) begin
                if (day_tick) m_seg = (m_seg + 1) % 7;
            end else if (m_press[0] && !m_press[1]) begin
                m_seg = (m_seg + 1) % 7;
            end else if (m_press[1] && !m_press[0]) begin
                m_seg = (m_seg + 6) % 7;
            end
            m_setcyc = (set_mode && m_set) ? m_setcyc + 1 : 0;
            m_set    = set_mode;
            m_raw[0] = btn_up;
            m_raw[1] = btn_down;
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) if (m_win[b][j] == m_lvl[b]) all_diff = 1'b0;
                m_press[b] = all_diff && !m_lvl[b];
                if (all_diff) m_lvl[b] = !m_lvl[b];
                for (int j = D - 1; j > 0; j--) m_win[b][j] = m_win[b][j-1];
                m_win[b][0] = m_raw[b];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("seg_vs_model", int'(seg), m_seg);
            check("blank_vs_model", int'(blank), int'(m_set && (((m_setcyc / H) % 2) == 1)));
            check("set_active_vs_model", int'(set_active), int'(m_set));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk) day_tick = 1'b1;
        @(negedge clk) day_tick = 1'b0;
    endtask

    task automatic press(input int b);
        @(negedge clk);
        if (b == 0) btn_up = 1'b1; else btn_down = 1'b1;
        idle(8);
        if (b == 0) btn_up = 1'b0; else btn_down = 1'b0;
        idle(8);
    endtask

    int tick_exp [8] = '{1, 2, 3, 4, 5, 6, 0, 1};
    int hold [2]     = '{0, 0};
    bit lv;

    initial begin
        idle(3);
        check("reset_seg", int'(seg), 0);
        check("reset_blank", int'(blank), 0);
        check("reset_set_active", int'(set_active), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            tick();
            check("run_tick_seq", int'(seg), tick_exp[i]);
            check("run_blank", int'(blank), 0);
        end

        @(negedge clk) set_mode = 1'b1;
        @(negedge clk);
        check("enter_set", int'(set_active), 1);
        press(1);
        check("down_to_mon", int'(seg), 0);

        btn_up = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            check("up_hold_latency", int'(seg), (e >= 5) ? 1 : 0);
        end
        btn_up = 1'b0;
        idle(8);
        check("up_no_repeat", int'(seg), 1);

        btn_up = 1'b1;
        idle(3);
        btn_up = 1'b0;
        idle(10);
        check("glitch_ignored", int'(seg), 1);

        press(1);
        press(1);
        check("down_wrap", int'(seg), 6);
        check("model_down_wrap", m_seg, 6);
        press(0);
        check("up_wrap", int'(seg), 0);

        @(negedge clk);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        idle(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(8);
        check("both_no_change", int'(seg), 0);

        tick();
        idle(1);
        check("tick_in_set_ignored", int'(seg), 0);

        @(negedge clk) set_mode = 1'b0;
        idle(2);
        tick();
        check("run_tick_after_set", int'(seg), 1);

        @(negedge clk) set_mode = 1'b1;
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            check("blink_phase", int'(blank), ((j % 16) >= 8) ? 1 : 0);
        end
        set_mode = 1'b0;
        @(negedge clk);
        check("exit_blank", int'(blank), 0);
        check("exit_set_active", int'(set_active), 0);

        for (int i = 0; i < 3; i++) tick();
        check("seg_before_reset", int'(seg), 4);
        check("model_before_reset", m_seg, 4);
        @(negedge clk) set_mode = 1'b1;
        idle(2);
        btn_up = 1'b1;
        idle(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_seg", int'(seg), 0);
        check("async_reset_blank", int'(blank), 0);
        check("async_reset_set_active", int'(set_active), 0);
        idle(2);
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            check("held_after_reset", int'(seg), (e >= 5) ? 1 : 0);
        end
        btn_up   = 1'b0;
        set_mode = 1'b0;
        idle(8);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            day_tick = !day_tick && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) set_mode = !set_mode;
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    lv      = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 12);
                    if (b == 0) btn_up = lv; else btn_down = lv;
                end else begin
                    hold[b]--;
                end
            end
        end
        day_tick = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
